// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: op codes,
// FSM state encoding and the index-counter width helper.
package addsub_serial_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_serial_chunk_adder.sv
// Gate-level full adder and the N-bit ripple adder built from it; the serial
// core reuses one chunk_adder every cycle.
module full_adder (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  logic w_axb;

  assign w_axb = a ^ b;
  assign s     = w_axb ^ ci;
  assign co    = (a & b) | (w_axb & ci);
endmodule

module chunk_adder #(
  parameter int N = 4
) (
  output logic [N-1:0] sum,
  output logic         cout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin
);
  logic [N:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .s  (sum[i]),
      .co (w_c[i+1]),
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i])
    );
  end

  assign cout = w_c[N];
endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, LSB
// chunk first, with one registered carry and a start/ready/done handshake.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             dbg_state
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("addsub_serial: illegal WIDTH/CHUNK combination");
  end

  // Handshake: a start is taken on a rising edge only while ready=1; done
  // pulses for one cycle with result/flags valid, and ready is high then too.
  state_t           r_state, w_state_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry, r_a_msb, r_b_msb;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_b_eff, w_result_next;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout, w_last;
  logic             r_done, r_cout, r_overflow, r_zero, r_negative;

  for (genvar i = 0; i < WIDTH; i++) begin : g_inv
    assign w_b_eff[i] = B[i] ^ op;
  end

  chunk_adder #(.N(CHUNK)) u_chunk (
    .sum  (w_sum),
    .cout (w_cout),
    .a    (r_a[CHUNK-1:0]),
    .b    (r_b[CHUNK-1:0]),
    .cin  (r_carry)
  );

  // Result shifts in from the top so the first chunk lands at the LSB after NCHUNK steps.
  assign w_result_next = (r_result >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));
  assign w_last        = (r_idx == IDXW'(NCHUNK - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_IDLE;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (r_state == ST_IDLE && start) begin
        r_a     <= A;
        r_b     <= w_b_eff;
        r_carry <= op;
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= w_b_eff[WIDTH-1];
        r_idx   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a      <= r_a >> CHUNK;
        r_b      <= r_b >> CHUNK;
        r_carry  <= w_cout;
        r_result <= w_result_next;
        r_idx    <= r_idx + 1'b1;
        if (w_last) begin
          r_idx      <= '0;
          r_done     <= 1'b1;
          r_cout     <= w_cout;
          r_overflow <= ~(r_a_msb ^ r_b_msb) & (r_a_msb ^ w_result_next[WIDTH-1]);
          r_zero     <= (w_result_next == '0);
          r_negative <= w_result_next[WIDTH-1];
        end
      end
    end
  end

  assign ready     = (r_state == ST_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: three instances (CHUNK 4, 16, 1) run the
// same directed vectors; a monitor checks result, flags and latency on done.
module tb_addsub_serial;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [3];
  logic        op_v    [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic [15:0] res_v   [3];
  logic        ready_v [3];
  logic        done_v  [3];
  logic        cout_v  [3];
  logic        ovf_v   [3];
  logic        zero_v  [3];
  logic        neg_v   [3];
  logic        dbg_v   [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  addsub_serial #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op_v[0]), .A(a_v[0]), .B(b_v[0]),
    .ready(ready_v[0]), .done(done_v[0]), .result(res_v[0]), .cout(cout_v[0]),
    .overflow(ovf_v[0]), .zero(zero_v[0]), .negative(neg_v[0]), .dbg_state(dbg_v[0]));

  addsub_serial #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op_v[1]), .A(a_v[1]), .B(b_v[1]),
    .ready(ready_v[1]), .done(done_v[1]), .result(res_v[1]), .cout(cout_v[1]),
    .overflow(ovf_v[1]), .zero(zero_v[1]), .negative(neg_v[1]), .dbg_state(dbg_v[1]));

  addsub_serial #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op_v[2]), .A(a_v[2]), .B(b_v[2]),
    .ready(ready_v[2]), .done(done_v[2]), .result(res_v[2]), .cout(cout_v[2]),
    .overflow(ovf_v[2]), .zero(zero_v[2]), .negative(neg_v[2]), .dbg_state(dbg_v[2]));

  // ---------------- directed vectors: {result, cout, ovf, zero, neg} ----------------
  localparam int NV = 7;
  logic        op_t  [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] a_t   [NV] = '{16'h1234, 16'h0005, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0000};
  logic [15:0] b_t   [NV] = '{16'h0FFF, 16'h0007, 16'h0001, 16'h0001, 16'h1234, 16'h0001, 16'h0001};
  logic [19:0] exp_t [NV] = '{{16'h2233, 4'b0000}, {16'hFFFE, 4'b0001}, {16'h8000, 4'b0101},
                              {16'h7FFF, 4'b1100}, {16'h0000, 4'b1010}, {16'h0000, 4'b1010},
                              {16'hFFFF, 4'b0001}};

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q0 [$];
  logic [19:0] exp_q1 [$];
  logic [19:0] exp_q2 [$];
  int          acc_q0 [$];
  int          acc_q1 [$];
  int          acc_q2 [$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 16;
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_exp(input int d, input logic [19:0] e, input int acc);
    case (d)
      0:       begin exp_q0.push_back(e); acc_q0.push_back(acc); end
      1:       begin exp_q1.push_back(e); acc_q1.push_back(acc); end
      default: begin exp_q2.push_back(e); acc_q2.push_back(acc); end
    endcase
  endtask

  task automatic pop_exp(input int d, output logic [19:0] e, output int acc);
    case (d)
      0:       begin e = exp_q0.pop_front(); acc = acc_q0.pop_front(); end
      1:       begin e = exp_q1.pop_front(); acc = acc_q1.pop_front(); end
      default: begin e = exp_q2.pop_front(); acc = acc_q2.pop_front(); end
    endcase
  endtask

  task automatic flush_all();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    acc_q0.delete(); acc_q1.delete(); acc_q2.delete();
  endtask

  task automatic check_done(input int d);
    logic [19:0] e, got;
    int          acc;
    got = {res_v[d], cout_v[d], ovf_v[d], zero_v[d], neg_v[d]};
    checks++;
    if (q_size(d) == 0) begin
      errors++;
      $display("FAIL unexpected_done dut%0d: got done with %h, required no done", d, got);
    end else begin
      pop_exp(d, e, acc);
      if (got !== e) begin
        errors++;
        $display("FAIL result_flags dut%0d: got %h, required %h", d, got, e);
      end
      checks++;
      if (cyc - acc != lat_of(d)) begin
        errors++;
        $display("FAIL latency dut%0d: got %0d cycles, required %0d", d, cyc - acc, lat_of(d));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) if (done_v[d] === 1'b1) check_done(d);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives start once ready is seen, then scrambles inputs.
  task automatic issue(input int d, input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic [19:0] e);
    int n = 0;
    while (ready_v[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready_v[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got ready=%b, required 1", d, ready_v[d]);
      return;
    end
    op_v[d]    = op;
    a_v[d]     = a;
    b_v[d]     = b;
    start_v[d] = 1'b1;
    push_exp(d, e, cyc + 1);
    @(negedge clk);
    start_v[d] = 1'b0;
    op_v[d]    = 1'($urandom_range(0, 1));
    a_v[d]     = 16'($urandom_range(0, 65535));
    b_v[d]     = 16'($urandom_range(0, 65535));
  endtask

  task automatic run_vecs(input int d);
    for (int i = 0; i < NV; i++) issue(d, op_t[i], a_t[i], b_t[i], exp_t[i]);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_size(0) + q_size(1) + q_size(2)) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((q_size(0) + q_size(1) + q_size(2)) != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding results, required 0",
               q_size(0) + q_size(1) + q_size(2));
    end
  endtask

  task automatic check_idle_outputs(input string name);
    logic [22:0] got;
    for (int d = 0; d < 3; d++) begin
      got = {ready_v[d], done_v[d], dbg_v[d], res_v[d], cout_v[d], ovf_v[d], zero_v[d], neg_v[d]};
      checks++;
      if (got !== {1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000}) begin
        errors++;
        $display("FAIL %s dut%0d: got %h, required %h", name, d, got,
                 {1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000});
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      op_v[d]    = 1'b0;
      a_v[d]     = '0;
      b_v[d]     = '0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic vectors on all three chunk sizes in parallel.
    fork
      run_vecs(0);
      run_vecs(1);
      run_vecs(2);
    join
    drain();

    // Handshake: ignored start while busy, then a start in the done cycle.
    issue(0, 1'b0, 16'h0001, 16'h0001, {16'h0002, 4'b0000});
    @(negedge clk);
    checks++;
    if (ready_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: got ready=%b, required 0", ready_v[0]);
    end
    op_v[0] = 1'b0; a_v[0] = 16'h0005; b_v[0] = 16'h0005; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (done_v[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_v[0] !== 1'b1 || ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle_ready: got done=%b ready=%b, required 1 1", done_v[0], ready_v[0]);
    end
    issue(0, 1'b1, 16'h0003, 16'h0001, {16'h0002, 4'b1000});
    drain();

    // Asynchronous reset mid-operation: outputs clear at once, no done follows.
    issue(0, 1'b0, 16'h1234, 16'h0FFF, {16'h2233, 4'b0000});
    issue(2, 1'b0, 16'h7FFF, 16'h0001, {16'h8000, 4'b0101});
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    flush_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Recovery after the abort.
    issue(0, 1'b1, 16'h0000, 16'h0001, {16'hFFFF, 4'b0001});
    issue(1, 1'b0, 16'h7FFF, 16'h0001, {16'h8000, 4'b0101});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
